// File: rtl/hex_ascii_to_word.sv
// ---------------------------------------------------------------------------
// hex_ascii_to_word
//   Assembles a stream of ASCII hex characters, MSB-first, into a packed word
//   for the CPU debug/load path. A terminator character ends a word early and
//   leaves the value right-aligned. Illegal characters pulse err and discard
//   the partial word.
//
//   Optional feature macro: LOWERCASE_HEX_EN
//     defined   -> 'a'-'f' are accepted as hex digits
//     undefined -> 'a'-'f' are illegal characters
//
// Parameters
//   NCHARS    hex digits per word (word width W = 4*NCHARS, NCHARS <= 15)
//   TERM_CHR  terminator character
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous reset, active-high
//   char_in     in   8   ASCII character
//   char_valid  in   1   char_in valid
//   char_ready  out  1   character can be accepted this cycle
//   word_out    out  W   assembled word, stable while word_valid=1
//   word_valid  out  1   word_out holds a complete word
//   word_ready  in   1   consumer accepts word_out
//   digit_cnt   out  4   digits collected in the current word
//   err         out  1   one-cycle pulse after an illegal character is accepted
// ---------------------------------------------------------------------------
module hex_ascii_to_word #(
    parameter int unsigned NCHARS   = 8,
    parameter logic [7:0]  TERM_CHR = 8'h0D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    output logic [4*NCHARS-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [3:0]            digit_cnt,
    output logic                  err
);

    localparam int unsigned W  = 4 * NCHARS;
    localparam int unsigned CW = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    acc, acc_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    word_n;
    logic            err_n;

    logic            is_hex;
    logic [3:0]      nib;
    logic [W-1:0]    acc_shift;
    logic [CW-1:0]   cnt_inc;

    // Hex character decode: {legal digit, nibble value}.
    // Letters share a low nibble of 1..6, so value = low nibble + 9.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
`ifdef LOWERCASE_HEX_EN
        else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
`else
        else begin
            r = 5'b0;
        end
`endif
        return r;
    endfunction

    assign {is_hex, nib} = hex_decode(char_in);
    assign acc_shift     = {acc[W-5:0], nib};
    assign cnt_inc       = cnt + CW'(1);

    // State-decoded handshake outputs; no input-to-output combinational path.
    assign char_ready = (state == COLLECT);
    assign word_valid = (state == HOLD);
    assign digit_cnt  = cnt;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            acc      <= '0;
            cnt      <= '0;
            word_out <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            word_out <= word_n;
            err      <= err_n;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        word_n  = word_out;
        err_n   = 1'b0;

        case (state)
            COLLECT: begin
                if (char_valid) begin
                    if (is_hex) begin
                        acc_n = acc_shift;
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(NCHARS)) begin
                            word_n  = acc_shift;
                            state_n = HOLD;
                        end
                    end else if (char_in == TERM_CHR) begin
                        // Terminator on an empty word is silently ignored.
                        if (cnt != '0) begin
                            word_n  = acc;
                            state_n = HOLD;
                        end
                    end else begin
                        err_n = 1'b1;
                        acc_n = '0;
                        cnt_n = '0;
                    end
                end
            end
            HOLD: begin
                // word_out stays frozen; only the accumulator is cleared.
                if (word_ready) begin
                    state_n = COLLECT;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_ascii_to_word.sv
// ---------------------------------------------------------------------------
// tb_hex_ascii_to_word
//   Directed self-checking bench for hex_ascii_to_word (NCHARS=8, W=32).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hex_ascii_to_word;

    logic        clk;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  digit_cnt;
    logic        err;

    int n_checks;
    int n_fail;

    hex_ascii_to_word #(
        .NCHARS   (8),
        .TERM_CHR (8'h0D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .digit_cnt  (digit_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one character starting at a falling edge; returns at the falling
    // edge after the character was accepted, with char_valid dropped.
    task automatic put(input logic [7:0] c);
        int n;
        char_in    = c;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check("put_timeout", 32'(char_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        word_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_word_out",   word_out,          32'h0);
        check("rst_word_valid", 32'(word_valid),   32'd0);
        check("rst_digit_cnt",  32'(digit_cnt),    32'd0);
        check("rst_err",        32'(err),          32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_char_ready", 32'(char_ready),   32'd1);

        // Test 1: full word, one char per cycle, consumer always ready
        word_ready = 1'b1;
        begin
            string s;
            s = "1234567";
            for (int i = 0; i < 7; i++) begin
                put(s[i]);
                check("t1_cnt",   32'(digit_cnt),  32'(i + 1));
                check("t1_valid", 32'(word_valid), 32'd0);
            end
        end
        put("8");
        check("t1_valid_hi", 32'(word_valid), 32'd1);
        check("t1_word",     word_out,        32'h12345678);
        check("t1_cnt_full", 32'(digit_cnt),  32'd8);
        check("t1_ready_lo", 32'(char_ready), 32'd0);
        @(negedge clk);
        check("t1_valid_lo", 32'(word_valid), 32'd0);
        check("t1_cnt_zero", 32'(digit_cnt),  32'd0);
        check("t1_ready_hi", 32'(char_ready), 32'd1);

        // Test 2: early termination, then terminator on an empty word
        word_ready = 1'b0;
        put_str("ABC");
        put(8'h0D);
        check("t2_valid", 32'(word_valid), 32'd1);
        check("t2_word",  word_out,        32'h00000ABC);
        check("t2_cnt",   32'(digit_cnt),  32'd3);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check("t2_released", 32'(word_valid), 32'd0);
        put(8'h0D);
        check("t2_empty_valid", 32'(word_valid), 32'd0);
        check("t2_empty_err",   32'(err),        32'd0);
        check("t2_empty_cnt",   32'(digit_cnt),  32'd0);

        // Test 3: illegal character clears the partial word
        put_str("12");
        check("t3_cnt_pre", 32'(digit_cnt), 32'd2);
        put("G");
        check("t3_err",     32'(err),       32'd1);
        check("t3_cnt_clr", 32'(digit_cnt), 32'd0);
        word_ready = 1'b1;
        put("D");
        check("t3_err_pulse", 32'(err),       32'd0);
        check("t3_cnt_one",   32'(digit_cnt), 32'd1);
        put_str("EADBEEF");
        check("t3_valid", 32'(word_valid), 32'd1);
        check("t3_word",  word_out,        32'hDEADBEEF);
        @(negedge clk);

        // Test 4: back-pressure while a word is held
        word_ready = 1'b0;
        put_str("CAFEF00D");
        check("t4_word", word_out, 32'hCAFEF00D);
        char_in    = "9";
        char_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_bp_ready", 32'(char_ready), 32'd0);
            check("t4_bp_word",  word_out,        32'hCAFEF00D);
            check("t4_bp_valid", 32'(word_valid), 32'd1);
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check("t4_rel_ready", 32'(char_ready), 32'd1);
        check("t4_rel_cnt",   32'(digit_cnt),  32'd0);
        @(negedge clk);
        char_valid = 1'b0;
        check("t4_first_digit", 32'(digit_cnt), 32'd1);
        word_ready = 1'b1;
        put_str("1234567");
        check("t4_word2", word_out, 32'h91234567);
        @(negedge clk);

        // Test 5: asynchronous reset mid-word
        put_str("1234");
        check("t5_cnt_pre", 32'(digit_cnt), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_cnt",   32'(digit_cnt),  32'd0);
        check("t5_rst_word",  word_out,        32'h0);
        check("t5_rst_valid", 32'(word_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        put_str("0000FFFF");
        check("t5_word", word_out, 32'h0000FFFF);
        @(negedge clk);

        // Test 6: lowercase digits
`ifdef LOWERCASE_HEX_EN
        put_str("deadbeef");
        check("t6_valid", 32'(word_valid), 32'd1);
        check("t6_word",  word_out,        32'hDEADBEEF);
        @(negedge clk);
`else
        put("d");
        check("t6_err", 32'(err),       32'd1);
        check("t6_cnt", 32'(digit_cnt), 32'd0);
        put_str("eadbeef");
        check("t6_no_valid", 32'(word_valid), 32'd0);
        check("t6_cnt_end",  32'(digit_cnt),  32'd0);
        check("t6_word_old", word_out,        32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
